mult_sym_pipe: RTL and testbench

//  Pipelined signed multiplier, W x W, with a symmetric input range. The most

---
 rtl/mult_pkg.sv | 43 ++++
 rtl/mult_pipe_ctrl.sv | 40 ++++
 rtl/mult_sym_pipe.sv | 128 ++++++++++++
 tb/tb_mult_sym_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the symmetric-range pipelined multiplier: default
// configuration, derived constants and the clamped-magnitude helper.
package mult_pkg;

    localparam int W_DEF     = 19;
    localparam int OUT_W_DEF = 2 * W_DEF - 1;
    localparam int SHIFT_DEF = 0;
    localparam int ROUND_DEF = 0;

    // Magnitude of a w-bit two's complement value, with -2^(w-1) folded onto
    // 2^(w-1)-1 so every operand has a representable negation.
    function automatic logic [31:0] sym_abs(input logic [31:0] x, input int w);
        logic [63:0] mask;
        logic [63:0] lim;
        logic [63:0] xe;
        logic [63:0] mag;
        mask = (64'd1 << w) - 64'd1;
        lim  = (64'd1 << (w - 1)) - 64'd1;
        xe   = {32'd0, x} & mask;
        if (((xe >> (w - 1)) & 64'd1) != 64'd0) begin
            mag = (~xe + 64'd1) & mask;
        end else begin
            mag = xe;
        end
        if (mag > lim) begin
            mag = lim;
        end
        return mag[31:0];
    endfunction

    function automatic logic [63:0] rnd_k(input int shift, input int round);
        return (round != 0 && shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
    endfunction

    function automatic logic [63:0] max_out(input int out_w);
        return (64'd1 << (out_w - 1)) - 64'd1;
    endfunction

    localparam int          MAG_W   = 2 * W_DEF - 2;
    localparam logic [63:0] RND_K   = rnd_k(SHIFT_DEF, ROUND_DEF);
    localparam logic [63:0] MAX_OUT = max_out(OUT_W_DEF);

endpackage

// File: rtl/mult_pipe_ctrl.sv
// Stage-valid shift register for a stall-all streaming pipeline: every stage
// advances together whenever the output slot is empty or being drained.
module mult_pipe_ctrl #(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              adv,
    output logic [STAGES-1:0] stage_valid
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    assign adv         = !valid_q[STAGES-1] | out_ready;
    assign in_ready    = adv;
    assign stage_valid = valid_q;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign valid_d[gi] = adv ? in_valid : valid_q[gi];
            end else begin : g_rest
                assign valid_d[gi] = adv ? valid_q[gi-1] : valid_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/mult_sym_pipe.sv
// Three-stage signed W x W multiplier with symmetric operand range, optional
// rounded right shift and symmetric saturation, valid/ready on both sides.
module mult_sym_pipe
    import mult_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int ROUND = ROUND_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] c,
    output logic             c_sat
);

    localparam int MAG_BITS = 2 * W - 2;
    localparam int P_W      = 2 * W - 1;
    localparam logic [P_W-1:0] RND_ADD = P_W'(rnd_k(SHIFT, ROUND));
    localparam logic [P_W-1:0] SAT_MAX = P_W'(max_out(OUT_W));

    generate
        if (W < 2 || W > 32) begin : g_bad_w
            $error("mult_sym_pipe: W must be in 2..32");
        end
        if (OUT_W < 2 || OUT_W > 2 * W - 1) begin : g_bad_out_w
            $error("mult_sym_pipe: OUT_W must be in 2..2*W-1");
        end
        if (SHIFT < 0 || SHIFT > 2 * W - 3) begin : g_bad_shift
            $error("mult_sym_pipe: SHIFT must be in 0..2*W-3");
        end
        if (ROUND != 0 && ROUND != 1) begin : g_bad_round
            $error("mult_sym_pipe: ROUND must be 0 or 1");
        end
    endgenerate

    logic       adv;
    logic [2:0] stage_valid;

    mult_pipe_ctrl #(
        .STAGES(3)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_ready   (in_ready),
        .adv        (adv),
        .stage_valid(stage_valid)
    );

    assign out_valid = stage_valid[2];

    // Stage 1: clamped magnitudes and result sign
    logic [W-2:0] a_mag_d, a_mag_q;
    logic [W-2:0] b_mag_d, b_mag_q;
    logic         sign1_d, sign1_q;

    assign a_mag_d = (W-1)'(sym_abs(32'(a), W));
    assign b_mag_d = (W-1)'(sym_abs(32'(b), W));
    // A zero operand must not yield a negative zero further down.
    assign sign1_d = (a[W-1] ^ b[W-1]) & (a_mag_d != '0) & (b_mag_d != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mag_q <= '0;
            b_mag_q <= '0;
            sign1_q <= 1'b0;
        end else if (adv && in_valid) begin
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            sign1_q <= sign1_d;
        end
    end

    // Stage 2: unsigned magnitude product
    logic [MAG_BITS-1:0] mag_d, mag_q;
    logic                sign2_q;

    assign mag_d = MAG_BITS'(a_mag_q) * MAG_BITS'(b_mag_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q   <= '0;
            sign2_q <= 1'b0;
        end else if (adv && stage_valid[0]) begin
            mag_q   <= mag_d;
            sign2_q <= sign1_q;
        end
    end

    // Stage 3: round, shift, saturate, re-apply sign. The extra top bit keeps
    // the rounding add from wrapping.
    logic [P_W-1:0]   sum_w;
    logic [P_W-1:0]   m_shift;
    logic             sat_d;
    logic [OUT_W-1:0] m_out;
    logic             neg_d;
    logic [OUT_W-1:0] c_d, c_q;
    logic             c_sat_q;

    assign sum_w   = {1'b0, mag_q} + RND_ADD;
    assign m_shift = sum_w >> SHIFT;
    assign sat_d   = m_shift > SAT_MAX;
    assign m_out   = OUT_W'(sat_d ? SAT_MAX : m_shift);
    assign neg_d   = sign2_q & (m_out != '0);
    assign c_d     = neg_d ? ((~m_out) + OUT_W'(1)) : m_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q     <= '0;
            c_sat_q <= 1'b0;
        end else if (adv && stage_valid[1]) begin
            c_q     <= c_d;
            c_sat_q <= sat_d;
        end
    end

    assign c     = c_q;
    assign c_sat = c_sat_q;

endmodule

// File: tb/tb_mult_sym_pipe.sv
// Scoreboard bench: four configurations driven in lockstep, expected results
// queued at accept and popped by a monitor at each output beat.
module tb_mult_sym_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [18:0] a = '0;
    logic [18:0] b = '0;

    logic        ir0, ir1, ir2, ir3;
    logic        ov0, ov1, ov2, ov3;
    logic        s0, s1, s2, s3;
    logic [36:0] c0, c2, c3;
    logic [19:0] c1;

    always #5 clk = ~clk;

    mult_sym_pipe u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
        .out_valid(ov0), .out_ready(out_ready), .c(c0), .c_sat(s0)
    );
    mult_sym_pipe #(.OUT_W(20)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready), .c(c1), .c_sat(s1)
    );
    mult_sym_pipe #(.SHIFT(4), .ROUND(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
        .out_valid(ov2), .out_ready(out_ready), .c(c2), .c_sat(s2)
    );
    mult_sym_pipe #(.SHIFT(4), .ROUND(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3), .a(a), .b(b),
        .out_valid(ov3), .out_ready(out_ready), .c(c3), .c_sat(s3)
    );

    logic        ov_a [4];
    logic [36:0] cv_a [4];
    logic        sv_a [4];
    assign ov_a[0] = ov0; assign cv_a[0] = c0;            assign sv_a[0] = s0;
    assign ov_a[1] = ov1; assign cv_a[1] = {17'd0, c1};   assign sv_a[1] = s1;
    assign ov_a[2] = ov2; assign cv_a[2] = c2;            assign sv_a[2] = s2;
    assign ov_a[3] = ov3; assign cv_a[3] = c3;            assign sv_a[3] = s3;

    typedef struct {
        logic [36:0] c;
        logic        sat;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q0[$], q1[$], q2[$], q3[$];
    exp_t e_mon;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int size_q(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic exp_t pop_q(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            2:       return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    // Reference: signed integer product on clamped operands, then magnitude
    // rounding/shift and symmetric saturation.
    function automatic void model(input logic [18:0] av, input logic [18:0] bv,
                                  input int ow, input int sh, input int rd,
                                  output logic [36:0] ce, output logic se);
        longint x, y, p, m, lim;
        bit     neg;
        x = longint'($signed(av));
        y = longint'($signed(bv));
        if (x == -262144) x = -262143;
        if (y == -262144) y = -262143;
        p   = x * y;
        neg = (p < 0);
        m   = neg ? -p : p;
        if (rd != 0 && sh > 0) m = m + (longint'(1) << (sh - 1));
        m   = m >> sh;
        lim = (longint'(1) << (ow - 1)) - 1;
        se  = (m > lim);
        if (se) m = lim;
        if (neg) m = -m;
        ce = 37'(m & ((longint'(1) << ow) - 1));
    endfunction

    // Drive one pair, wait for acceptance, queue expectations for all four DUTs.
    task automatic send(input logic [18:0] av, input logic [18:0] bv,
                        input logic [36:0] e0, input logic x0,
                        input logic [36:0] e1, input logic x1,
                        input logic [36:0] e2, input logic x2,
                        input logic [36:0] e3, input logic x3,
                        input bit lat);
        int guard;
        guard = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!ir0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ir0) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: in_ready stuck low for a=%h b=%h", av, bv);
        end
        @(posedge clk);
        #1;
        n_acc++;
        q0.push_back('{c: e0, sat: x0, acc: cyc, lat: lat});
        q1.push_back('{c: e1, sat: x1, acc: cyc, lat: lat});
        q2.push_back('{c: e2, sat: x2, acc: cyc, lat: lat});
        q3.push_back('{c: e3, sat: x3, acc: cyc, lat: lat});
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
    endtask

    task automatic send_model(input logic [18:0] av, input logic [18:0] bv);
        logic [36:0] e0, e1, e2, e3;
        logic        x0, x1, x2, x3;
        model(av, bv, 37, 0, 0, e0, x0);
        model(av, bv, 20, 0, 0, e1, x1);
        model(av, bv, 37, 4, 1, e2, x2);
        model(av, bv, 37, 4, 0, e3, x3);
        send(av, bv, e0, x0, e1, x1, e2, x2, e3, x3, 1'b0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_empty", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_ready) begin
            for (int i = 0; i < 4; i++) begin
                if (ov_a[i]) begin
                    if (size_q(i) == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL u%0d_unexpected: got c=%h with no result pending", i, cv_a[i]);
                    end else begin
                        e_mon = pop_q(i);
                        chk($sformatf("u%0d_c", i), 64'(cv_a[i]), 64'(e_mon.c));
                        chk($sformatf("u%0d_sat", i), 64'(sv_a[i]), 64'(e_mon.sat));
                        if (e_mon.lat) chk($sformatf("u%0d_latency", i), 64'(cyc + 1 - e_mon.acc), 64'd3);
                        if (i == 0) $display("beat t=%0t u0 c=%h sat=%b exp=%h", $time, c0, s0, e_mon.c);
                    end
                end
            end
        end
    end

    initial begin
        logic [18:0] ra, rb;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(ov0), 64'd0);
        chk("reset_c", 64'(c0), 64'd0);
        chk("reset_c_sat", 64'(s0), 64'd0);
        chk("reset_in_ready", 64'(ir0), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back to back, latency checked
        send(19'h40000, 19'h00001, 37'h1FFFFC0001, 0, 37'h00000C0001, 0, 37'h1FFFFFC000, 0, 37'h1FFFFFC001, 0, 1);
        send(19'h00000, 19'h7FFFF, 37'h0, 0, 37'h0, 0, 37'h0, 0, 37'h0, 0, 1);
        send(19'h7FFFF, 19'h7FFFF, 37'h1, 0, 37'h1, 0, 37'h0, 0, 37'h0, 0, 1);
        send(19'h3FFFF, 19'h3FFFF, 37'h0FFFF80001, 0, 37'h7FFFF, 1, 37'h00FFFF8000, 0, 37'h00FFFF8000, 0, 1);
        send(19'h00003, 19'h7FFFD, 37'h1FFFFFFFF7, 0, 37'hFFFF7, 0, 37'h1FFFFFFFFF, 0, 37'h0, 0, 1);
        send(19'h3FFFF, 19'h40000, 37'h100007FFFF, 0, 37'h80001, 1, 37'h1F00008000, 0, 37'h1F00008000, 0, 1);
        send(19'h40000, 19'h40000, 37'h0FFFF80001, 0, 37'h7FFFF, 1, 37'h00FFFF8000, 0, 37'h00FFFF8000, 0, 1);
        send(19'h7FFF8, 19'h00001, 37'h1FFFFFFFF8, 0, 37'hFFFF8, 0, 37'h1FFFFFFFFF, 0, 37'h0, 0, 1);
        send(19'h00008, 19'h00001, 37'h8, 0, 37'h8, 0, 37'h1, 0, 37'h0, 0, 1);
        drain();

        // Backpressure: stall the sink for five cycles mid-stream
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ra = 19'($urandom());
                    rb = 19'($urandom());
                    send_model(ra, rb);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) chk("accepted_before_stall", 64'(n_acc), 64'd3);
                    chk("stall_in_ready", 64'(ir0), 64'd0);
                    chk("stall_out_valid", 64'(ov0), 64'd1);
                    if (q0.size() != 0) chk("stall_c_held", 64'(c0), 64'(q0[0].c));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with results in flight
        out_ready = 1'b0;
        send(19'h00002, 19'h00003, 37'h6, 0, 37'h6, 0, 37'h0, 0, 37'h0, 0, 0);
        send(19'h00005, 19'h00007, 37'h23, 0, 37'h23, 0, 37'h2, 0, 37'h2, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", 64'(ov0), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_out_valid_u0", 64'(ov0), 64'd0);
        chk("async_reset_out_valid_u1", 64'(ov1), 64'd0);
        chk("async_reset_out_valid_u2", 64'(ov2), 64'd0);
        chk("async_reset_c", 64'(c0), 64'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_idle", 64'(ov0), 64'd0);
        send(19'h40000, 19'h00001, 37'h1FFFFC0001, 0, 37'h00000C0001, 0, 37'h1FFFFFC000, 0, 37'h1FFFFFC001, 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
